fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction prefetch unit that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues word fetches to a variable-latency instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions, each paired with its PC+4, in a small FIFO that the IF/ID register drains.
- Accepts a redirect (branch/jump resolution from the hazard unit), which discards all buffered and in-flight instructions and restarts fetch at the new PC.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h00400000, first fetch address after reset.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- imem_req  output  1  fetch request valid
- imem_addr  output  32  fetch byte address, word aligned
- imem_gnt  input  1  memory accepts the request this cycle (req & gnt = accepted)
- imem_rvalid  input  1  response valid; arrives at least 1 cycle after gnt, in order
- imem_rdata  input  32  returned instruction
- fq_valid  output  1  FIFO head is valid
- fq_inst  output  32  head instruction
- fq_pc_4  output  32  head instruction address + 4
- fq_ready  input  1  IF/ID accepts the head (pop = fq_valid & fq_ready)
- redirect  input  1  flush and refetch
- redirect_pc  input  32  new fetch address, bits [1:0] ignored (treated as 0)

Behaviour:
- Reset (async assert): fetch_pc=RESET_PC, state=RUN, FIFO empty, imem_req=0, fq_valid=0. Outputs fq_inst and fq_pc_4 are 0 while empty.
- At most one request is outstanding at a time. States:
  - RUN: nothing outstanding.
  - WAIT: one valid request outstanding.
  - DISCARD: one stale request outstanding.
- RUN: imem_req=1 iff FIFO count < DEPTH and redirect=0; imem_addr=fetch_pc.
  - On gnt: go to WAIT and set fetch_pc += 4. Wraps modulo 2^32: 32'hFFFFFFFC goes to 0.
- Request stability: while imem_req=1 and gnt=0, imem_addr stays stable. The only exception is a redirect, which retargets the address in the next cycle.
- WAIT: on rvalid, push {imem_rdata, addr+4} and go to RUN. The next request issues the following cycle, so throughput is at most 1 instruction per 2 cycles.
  - A FIFO slot is guaranteed because the request was issued only when count < DEPTH and pushes happen only in WAIT.
- DISCARD: drop imem_rdata on rvalid, then go to RUN.
- Redirect in cycle t:
  - In cycle t, fq_valid is forced to 0, so no pop occurs.
  - In cycle t+1: FIFO is empty and fetch_pc = redirect_pc.
  - State at t+1:
    - RUN → RUN, with the request for redirect_pc asserted at t+1.
    - RUN with gnt in cycle t: impossible, because imem_req=0 during redirect.
    - WAIT without rvalid in t → DISCARD.
    - WAIT with rvalid in t → the response is dropped, no push, state=RUN.
    - DISCARD stays DISCARD, or goes to RUN if rvalid occurs in t.
- Back-to-back redirects: the last one wins. Each redirect clears the FIFO again.
- Simultaneous push and pop: allowed, and the count is unchanged.
  - Pop on empty cannot occur, since fq_valid=0.
  - Push on full cannot occur, by construction.
- FIFO output is the combinational head (zero-cycle read). fq_valid = !empty & !redirect.
- Async reset mid-operation: everything returns to reset values immediately. Any response that arrives later is ignored because the state is RUN.
- rvalid in RUN (protocol violation): ignored.

Decomposition:
- Shared package cpu_pkg holds:
  - INST_W=32, ADDR_W=32
  - RESET_PC constant
  - state enum {FQ_RUN, FQ_WAIT, FQ_DISCARD}
- Sub-module fq_fifo: synchronous FIFO of DEPTH×64 bits with push, pop, flush, count, full and empty, plus a combinational head. It uses the same clk and rst.
- fetch_queue holds the FSM, fetch_pc and the handshake logic only.

Test Plan:
- Reset, then zero-wait memory (gnt=1, rvalid one cycle after gnt), fq_ready=1 → addresses 0x00400000, 0x00400004 and onward issue every 2 cycles. Heads carry fq_pc_4=0x00400004, 0x00400008 with matching instructions.
- fq_ready=0 with DEPTH=4 → exactly 4 requests are granted, then imem_req stays 0. Raising fq_ready pops 4 entries in order, and requests resume.
- Redirect to 0x00400100 while in WAIT, with rvalid 3 cycles later → the stale response is not pushed, the next imem_addr is 0x00400100, and the first head has fq_pc_4=0x00400104.
- Redirect in the same cycle as rvalid, with a FIFO holding 2 entries → fq_valid=0 that cycle, the FIFO is empty next cycle, and the request for redirect_pc is asserted next cycle.
- gnt held low for 5 cycles → imem_req and imem_addr are stable throughout. A redirect in cycle 3 changes imem_addr to redirect_pc in cycle 4.
- Assert rst mid-WAIT, with rvalid arriving during/after reset → outputs return to reset values, nothing is pushed, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg: widths, reset vector and fetch-queue state encoding.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0040_0000;

  typedef enum logic [1:0] {
    FQ_RUN     = 2'd0,
    FQ_WAIT    = 2'd1,
    FQ_DISCARD = 2'd2
  } fq_state_t;

endpackage
`default_nettype wire

// File: rtl/fq_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fq_fifo: DEPTH-entry FIFO with flush and a zero-latency head.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int                c_ptr_w      = $clog2(DEPTH);
  localparam logic [c_ptr_w:0]  c_full_count = DEPTH[c_ptr_w:0];

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;

  // Storage carries no reset; validity is tracked entirely by r_count.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        r_count <= r_count + 1'b1;
      end else if (pop && !push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == c_full_count);

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue: single-outstanding instruction prefetcher feeding IF/ID.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        fq_valid,
  output logic [31:0] fq_inst,
  output logic [31:0] fq_pc_4,
  input  logic        fq_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  import cpu_pkg::*;

  localparam int c_entry_w = INST_W + ADDR_W;

  fq_state_t             r_state;
  fq_state_t             w_state_nxt;
  logic [ADDR_W-1:0]     r_fetch_pc;
  logic [ADDR_W-1:0]     w_fetch_pc_nxt;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [c_entry_w-1:0]  w_head;
  logic [$clog2(DEPTH):0] w_unused_count;
  logic [1:0]            w_unused_pc_lo;

  assign w_unused_pc_lo = redirect_pc[1:0];

  // A request is only raised when the FIFO can absorb its response.
  assign imem_req  = (r_state == FQ_RUN) && !w_full && !redirect && !rst;
  assign imem_addr = r_fetch_pc;

  assign fq_valid  = !w_empty && !redirect;
  assign w_pop     = fq_valid && fq_ready;
  assign {fq_inst, fq_pc_4} = w_empty ? '0 : w_head;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_push         = 1'b0;
    if (redirect) begin
      w_fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
      case (r_state)
        FQ_WAIT, FQ_DISCARD: w_state_nxt = imem_rvalid ? FQ_RUN : FQ_DISCARD;
        default:             w_state_nxt = FQ_RUN;
      endcase
    end else begin
      case (r_state)
        FQ_RUN: begin
          if (imem_req && imem_gnt) begin
            w_state_nxt    = FQ_WAIT;
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          end
        end
        FQ_WAIT: begin
          // r_fetch_pc already holds the outstanding address + 4.
          if (imem_rvalid) begin
            w_push      = 1'b1;
            w_state_nxt = FQ_RUN;
          end
        end
        FQ_DISCARD: begin
          if (imem_rvalid) begin
            w_state_nxt = FQ_RUN;
          end
        end
        default: w_state_nxt = FQ_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FQ_RUN;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  fq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (c_entry_w)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data ({imem_rdata, r_fetch_pc}),
    .pop       (w_pop),
    .flush     (redirect),
    .head      (w_head),
    .count     (w_unused_count),
    .full      (w_full),
    .empty     (w_empty)
  );

endmodule
`default_nettype wire
